// File: rtl/mips_instr_encoder_if.sv
// Request/instruction handshake bundle for mips_instr_encoder.
// master = request producer and instruction consumer; slave = the encoder.
interface mips_instr_encoder_if #(
  parameter int OUT_DEPTH = 4
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [4:0]    req_rd;
  logic [4:0]    req_shamt;
  logic [31:0]   req_imm;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_word;
  logic          instr_last;
  logic [CW-1:0] instr_count;
  logic          err_illegal;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, instr_ready,
    input  req_ready, instr_valid, instr_word, instr_last, instr_count, err_illegal
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, instr_ready,
    output req_ready, instr_valid, instr_word, instr_last, instr_count, err_illegal
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Field-level MIPS32 encoder: one request -> 1..2 words into an output FIFO, LI expanded.
// Optional DELAY_SLOT_NOP_EN appends a NOP word after every branch/jump.
module mips_instr_encoder #(
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  mips_instr_encoder_if.slave bus
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [4:0] OP_ADDU  = 5'd1,  OP_SUBU = 5'd2,  OP_AND  = 5'd3,  OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5,  OP_NOR  = 5'd6,  OP_SLT  = 5'd7,  OP_SLTU = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9,  OP_SRL  = 5'd10, OP_SRA  = 5'd11, OP_ADDIU = 5'd12;
  localparam logic [4:0] OP_ORI   = 5'd13, OP_ANDI = 5'd14, OP_XORI = 5'd15, OP_LUI  = 5'd16;
  localparam logic [4:0] OP_LW    = 5'd17, OP_SW   = 5'd18, OP_BEQ  = 5'd19, OP_BNE  = 5'd20;
  localparam logic [4:0] OP_J     = 5'd21, OP_JAL  = 5'd22, OP_JR   = 5'd23, OP_LI   = 5'd24;
  localparam logic [4:0] OP_MFC0  = 5'd25, OP_MTC0 = 5'd26, OP_ERET = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT2
`ifdef DELAY_SLOT_NOP_EN
    , ST_EMIT_NOP
`endif
  } state_t;

  function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encode(input logic [4:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADDU:  w = r_fmt(rs, rt, rd, 5'd0, 6'h21);
      OP_SUBU:  w = r_fmt(rs, rt, rd, 5'd0, 6'h23);
      OP_AND:   w = r_fmt(rs, rt, rd, 5'd0, 6'h24);
      OP_OR:    w = r_fmt(rs, rt, rd, 5'd0, 6'h25);
      OP_XOR:   w = r_fmt(rs, rt, rd, 5'd0, 6'h26);
      OP_NOR:   w = r_fmt(rs, rt, rd, 5'd0, 6'h27);
      OP_SLT:   w = r_fmt(rs, rt, rd, 5'd0, 6'h2a);
      OP_SLTU:  w = r_fmt(rs, rt, rd, 5'd0, 6'h2b);
      OP_SLL:   w = r_fmt(5'd0, rt, rd, sh, 6'h00);
      OP_SRL:   w = r_fmt(5'd0, rt, rd, sh, 6'h02);
      OP_SRA:   w = r_fmt(5'd0, rt, rd, sh, 6'h03);
      OP_ADDIU: w = i_fmt(6'h09, rs, rt, imm[15:0]);
      OP_ORI:   w = i_fmt(6'h0d, rs, rt, imm[15:0]);
      OP_ANDI:  w = i_fmt(6'h0c, rs, rt, imm[15:0]);
      OP_XORI:  w = i_fmt(6'h0e, rs, rt, imm[15:0]);
      OP_LUI:   w = i_fmt(6'h0f, 5'd0, rt, imm[15:0]);
      OP_LW:    w = i_fmt(6'h23, rs, rt, imm[15:0]);
      OP_SW:    w = i_fmt(6'h2b, rs, rt, imm[15:0]);
      OP_BEQ:   w = i_fmt(6'h04, rs, rt, imm[15:0]);
      OP_BNE:   w = i_fmt(6'h05, rs, rt, imm[15:0]);
      OP_J:     w = {6'h02, imm[25:0]};
      OP_JAL:   w = {6'h03, imm[25:0]};
      OP_JR:    w = r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h08);
      // LI: a single ORI when the upper half is zero, otherwise the LUI half goes first
      OP_LI:    w = (imm[31:16] == 16'h0) ? i_fmt(6'h0d, 5'd0, rt, imm[15:0])
                                          : i_fmt(6'h0f, 5'd0, rt, imm[31:16]);
      OP_MFC0:  w = {6'h10, 5'h00, rt, rd, 8'h00, imm[2:0]};
      OP_MTC0:  w = {6'h10, 5'h04, rt, rd, 8'h00, imm[2:0]};
      OP_ERET:  w = 32'h4200_0018;
      default:  w = '0;
    endcase
    return w;
  endfunction

  state_t        state;
  logic          out_of_reset;
  logic          err_q;
  logic [4:0]    li_rt_p1;
  logic [15:0]   li_lo_p1;

  logic [32:0]   mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          accept;
  logic          illegal_p0, li_two_p0, word0_last_p0;
  logic [31:0]   word0_p0;
  logic          push, pop;
  logic [31:0]   push_word;
  logic          push_last;

  assign full  = (count == CW'(OUT_DEPTH));
  assign empty = (count == '0);

  assign bus.req_ready = out_of_reset & (state == ST_IDLE) & ~full & ~flush;
  assign accept        = bus.req_valid & bus.req_ready;

  // ---- p0: combinational encode of the presented request
  assign illegal_p0 = (bus.req_op[4:2] == 3'b111);
  assign li_two_p0  = (bus.req_op == OP_LI) && (bus.req_imm[31:16] != 16'h0);
  assign word0_p0   = encode(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd,
                             bus.req_shamt, bus.req_imm);

`ifdef DELAY_SLOT_NOP_EN
  logic is_branch_p0;
  assign is_branch_p0  = (bus.req_op == OP_BEQ) || (bus.req_op == OP_BNE) ||
                         (bus.req_op == OP_J)   || (bus.req_op == OP_JAL) ||
                         (bus.req_op == OP_JR);
  assign word0_last_p0 = ~(li_two_p0 | is_branch_p0);
`else
  assign word0_last_p0 = ~li_two_p0;
`endif

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (accept && !illegal_p0) begin
            push      = 1'b1;
            push_word = word0_p0;
            push_last = word0_last_p0;
          end
        end
        ST_EMIT2: begin
          if (!full) begin
            push      = 1'b1;
            push_word = i_fmt(6'h0d, li_rt_p1, li_rt_p1, li_lo_p1);
            push_last = 1'b1;
          end
        end
`ifdef DELAY_SLOT_NOP_EN
        ST_EMIT_NOP: begin
          if (!full) begin
            push      = 1'b1;
            push_word = '0;
            push_last = 1'b1;
          end
        end
`endif
        default: push = 1'b0;
      endcase
    end
  end

  assign pop = bus.instr_ready & ~empty & ~flush;

  // ---- p1: FSM, captured LI fields and output FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      out_of_reset <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      err_q        <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (illegal_p0)     err_q <= 1'b1;
              else if (li_two_p0) state <= ST_EMIT2;
`ifdef DELAY_SLOT_NOP_EN
              else if (is_branch_p0) state <= ST_EMIT_NOP;
`endif
            end
          end
          ST_EMIT2: if (!full) state <= ST_IDLE;
`ifdef DELAY_SLOT_NOP_EN
          ST_EMIT_NOP: if (!full) state <= ST_IDLE;
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      li_rt_p1 <= bus.req_rt;
      li_lo_p1 <= bus.req_imm[15:0];
    end
    if (push) mem[wr_ptr] <= {push_last, push_word};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head fields read as zero when the FIFO is empty so stale entries never leak out.
  assign bus.instr_valid = ~empty;
  assign bus.instr_word  = empty ? 32'h0 : mem[rd_ptr][31:0];
  assign bus.instr_last  = empty ? 1'b0  : mem[rd_ptr][32];
  assign bus.instr_count = count;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed known answers plus randomized
// requests checked against a field-table reference model.
`timescale 1ns/1ps
module tb_mips_instr_encoder;
  localparam int OUT_DEPTH = 4;
`ifdef DELAY_SLOT_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  localparam int unsigned RFN  [8] = '{32'h21, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2a, 32'h2b};
  localparam int unsigned SFN  [3] = '{32'h00, 32'h02, 32'h03};
  localparam int unsigned IOPC [9] = '{32'h09, 32'h0d, 32'h0c, 32'h0e, 32'h0f, 32'h23, 32'h2b, 32'h04, 32'h05};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;

  mips_instr_encoder_if #(.OUT_DEPTH(OUT_DEPTH)) bus ();
  mips_instr_encoder #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  bit mon_en = 1'b0;
  bit err_pending = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int unsigned rword(input int unsigned opc, input int unsigned rs,
                                        input int unsigned rt, input int unsigned rd,
                                        input int unsigned sh, input int unsigned fn);
    return (opc << 26) | (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
  endfunction

  task automatic model(input int unsigned op, input int unsigned rs, input int unsigned rt,
                       input int unsigned rd, input int unsigned sh, input int unsigned imm);
    int unsigned w;
    bit br;
    br = 1'b0;
    if (op == 0) w = 0;
    else if (op <= 8)  w = rword(0, rs, rt, rd, 0, RFN[op-1]);
    else if (op <= 11) w = rword(0, 0, rt, rd, sh, SFN[op-9]);
    else if (op <= 20) begin
      w  = rword(IOPC[op-12], (op == 16) ? 0 : rs, rt, 0, 0, 0) | (imm & 32'hffff);
      br = (op >= 19);
    end else if (op <= 22) begin
      w  = ((op - 19) << 26) | (imm & 32'h03ff_ffff);
      br = 1'b1;
    end else if (op == 23) begin
      w  = rword(0, rs, 0, 0, 0, 8);
      br = 1'b1;
    end else if (op == 24) begin
      if ((imm >> 16) == 0) w = rword(13, 0, rt, 0, 0, 0) | imm;
      else begin
        exp_q.push_back({1'b0, rword(15, 0, rt, 0, 0, 0) | (imm >> 16)});
        w = rword(13, rt, rt, 0, 0, 0) | (imm & 32'hffff);
      end
    end
    else if (op == 25) w = rword(16, 0, rt, rd, 0, 0) | (imm & 7);
    else if (op == 26) w = rword(16, 4, rt, rd, 0, 0) | (imm & 7);
    else if (op == 27) w = 32'h4200_0018;
    else return;
    if (br && NOP_EN) begin
      exp_q.push_back({1'b0, w});
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      exp_q.push_back({1'b1, w});
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int unsigned op, input int unsigned rs, input int unsigned rt,
                      input int unsigned rd, input int unsigned sh, input int unsigned imm,
                      input bit use_model);
    int waited;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op[4:0];
    bus.req_rs    = rs[4:0];
    bus.req_rt    = rt[4:0];
    bus.req_rd    = rd[4:0];
    bus.req_shamt = sh[4:0];
    bus.req_imm   = imm;
    #1;
    while (!bus.req_ready && waited < 300) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: req_ready got 0, required 1 (op %0d)", op);
      bus.req_valid = 1'b0;
      return;
    end
    if (use_model) model(op, rs, rt, rd, sh, imm);
    @(posedge clk);
    if (op >= 28) err_pending = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.instr_count != 0) && n < 400) begin
      @(negedge clk); #3;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.instr_count != 0) begin
      n_fail++;
      $display("FAIL drain: count %0d, pending %0d, required 0/0", bus.instr_count, exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk); #2;
    if (rand_ready) bus.instr_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every consumer handshake and checks the error pulse.
  initial forever begin
    logic [32:0] e;
    @(negedge clk); #2;
    if (mon_en) begin
      check("err_illegal", bus.err_illegal, err_pending);
      err_pending = 1'b0;
      if (bus.instr_valid && bus.instr_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h, required no word", bus.instr_word);
        end else begin
          e = exp_q.pop_front();
          check("instr_word", bus.instr_word, e[31:0]);
          check("instr_last", bus.instr_last, e[32]);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op, imm;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0;
    bus.req_rd = '0; bus.req_shamt = '0; bus.req_imm = '0; bus.instr_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_instr_valid", bus.instr_valid, 0);
    check("reset_instr_word", bus.instr_word, 0);
    check("reset_instr_last", bus.instr_last, 0);
    check("reset_count", bus.instr_count, 0);
    check("reset_err", bus.err_illegal, 0);
    @(negedge clk) resetn = 1'b1;
    idle(2); #1;
    check("ready_after_reset", bus.req_ready, 1);
    mon_en = 1'b1;
    bus.instr_ready = 1'b1;

    // ADDU known answer and latency 1
    exp_q.push_back({1'b1, 32'h0022_1821});
    send(1, 1, 2, 3, 0, 0, 0);
    check("addu_latency_valid", bus.instr_valid, 1);
    check("addu_count", bus.instr_count, 1);
    wait_drain();

    // LI two-word and single-word forms
    exp_q.push_back({1'b0, 32'h3C08_1234});
    exp_q.push_back({1'b1, 32'h3508_5678});
    send(24, 0, 8, 0, 0, 32'h1234_5678, 0);
    check("li_ready_between", bus.req_ready, 0);
    wait_drain();
    exp_q.push_back({1'b1, 32'h3404_0042});
    send(24, 0, 4, 0, 0, 32'h0000_0042, 0);
    wait_drain();

    // BEQ with optional delay-slot NOP
    exp_q.push_back({~NOP_EN, 32'h1022_0003});
    if (NOP_EN) exp_q.push_back({1'b1, 32'h0});
    send(19, 1, 2, 0, 0, 3, 0);
    wait_drain();

    // Fill to full with the consumer stalled, then drain in order
    @(negedge clk) bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1, i + 1, i + 2, i + 3, 0, 0, 1);
    check("full_count", bus.instr_count, 4);
    check("full_req_ready", bus.req_ready, 0);
    bus.instr_ready = 1'b1;
    wait_drain();

    // Illegal op: pulse and nothing written
    send(31, 3, 4, 5, 6, 32'hdead_beef, 1);
    check("illegal_count", bus.instr_count, 0);
    wait_drain();

    // LI second half held while full, then released without loss
    @(negedge clk) bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4, i, i + 7, i + 9, 0, 0, 1);
    send(24, 0, 6, 0, 0, 32'h8765_4321, 1);
    idle(4); #1;
    check("hold_count", bus.instr_count, 4);
    check("hold_req_ready", bus.req_ready, 0);
    bus.instr_ready = 1'b1;
    wait_drain();

    // Flush after the LUI half of an LI
    @(negedge clk) bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2, i, i + 1, i + 2, 0, 0, 1);
    send(24, 0, 5, 0, 0, 32'hABCD_1234, 1);
    idle(2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    #1;
    check("flush_count", bus.instr_count, 0);
    check("flush_valid", bus.instr_valid, 0);
    check("flush_idle_ready", bus.req_ready, 1);
    bus.instr_ready = 1'b1;

    // Randomized traffic against the reference model
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op  = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 27);
      imm = $urandom;
      if (op == 24 && $urandom_range(0, 1) == 1) imm = imm & 32'hffff;
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    @(negedge clk);
    rand_ready = 1'b0;
    @(posedge clk); #3;
    bus.instr_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
